// File: rtl/vme_cycle_decode.sv
// vme_cycle_decode: front end of the VME slave interface.
// Synchronizes AS/DS/DTACK to FASTCLK, qualifies slot and address modifier,
// drives the STROBE/WRITE_B/DEVICE/COMMAND bus for downstream device blocks,
// and aborts with BERR when no device acknowledges within TIMEOUT_CYCLES.
//
// Optional feature macro: GA_PARITY_CHECK_EN
//   When defined, adds GAP_B input and GA_PERR output; the slot only matches
//   when {GA, ~GAP_B} has odd parity.
//
// Handshake: the master opens a cycle with AS low, then DS low for the data
// phase. STROBE is the data-phase qualifier; a device completes the phase by
// pulling the shared DTACK line low, and the master ends it by raising DS.
// A new cycle is only accepted once both AS and DS have returned high.

module vme_cycle_decode #(
    parameter int          SYNC_STAGES    = 2,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [5:0]  AM_A24_DATA    = 6'h39,
    parameter logic [5:0]  AM_A24_SUPER   = 6'h3D
) (
    input  logic        FASTCLK,
    input  logic        RST,
    input  logic        VME_AS_B,
    input  logic [1:0]  VME_DS_B,
    input  logic        VME_WRITE_B,
    input  logic [5:0]  VME_AM,
    input  logic [22:0] VME_ADDR,
    input  logic [4:0]  GA,
    input  logic        DTACK_FB_B,
`ifdef GA_PARITY_CHECK_EN
    input  logic        GAP_B,
    output logic        GA_PERR,
`endif
    output logic        STROBE,
    output logic        WRITE_B,
    output logic [15:0] DEVICE,
    output logic [9:0]  COMMAND,
    output logic        BERR_B,
    output logic        TIMEOUT,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LATCH   = 3'd1,
        WAIT_DS = 3'd2,
        STRB    = 3'd3,
        ABORT   = 3'd4,
        RELEASE = 3'd5
    } state_t;

    localparam logic [9:0] TO_LIM = 10'(TIMEOUT_CYCLES);

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] as_sr, ds_sr, dtack_sr;
    logic sync_as, sync_ds, sync_dtack;

    logic [9:0]  cnt, cnt_n, cnt_inc;
    logic        strobe_n, write_b_n, berr_b_n, timeout_n;
    logic [15:0] device_n;
    logic [9:0]  command_n;
    logic        match;
    logic        slot_ok, am_ok, parity_ok;

    // A18..A16 and A1 are not part of the decode.
    logic unused_addr;
    assign unused_addr = ^{VME_ADDR[17:15], VME_ADDR[0]};

    assign sync_as    = as_sr[SYNC_STAGES-1];
    assign sync_ds    = ds_sr[SYNC_STAGES-1];
    assign sync_dtack = dtack_sr[SYNC_STAGES-1];
    assign state_dbg  = state;

    // Synchronizer chains; idle level is 1 (all strobes inactive).
    always_ff @(posedge FASTCLK) begin
        if (RST) begin
            as_sr    <= '1;
            ds_sr    <= '1;
            dtack_sr <= '1;
        end else begin
            as_sr    <= {as_sr[SYNC_STAGES-2:0], VME_AS_B};
            ds_sr    <= {ds_sr[SYNC_STAGES-2:0], &VME_DS_B};
            dtack_sr <= {dtack_sr[SYNC_STAGES-2:0], DTACK_FB_B};
        end
    end

`ifdef GA_PARITY_CHECK_EN
    assign parity_ok = ^{GA, ~GAP_B};

    // Parity status is refreshed every cycle so a bad backplane pin is visible.
    always_ff @(posedge FASTCLK) begin
        if (RST) begin
            GA_PERR <= 1'b0;
        end else begin
            GA_PERR <= ~parity_ok;
        end
    end
`else
    assign parity_ok = 1'b1;
`endif

    // Address/AM are stable by the time synced AS has reached the FSM.
    assign slot_ok = (VME_ADDR[22:18] == GA) && (GA != 5'd0);
    assign am_ok   = (VME_AM == AM_A24_DATA) || (VME_AM == AM_A24_SUPER);
    assign match   = slot_ok && am_ok && parity_ok;

    // Saturating increment so the counter can never wrap past the limit.
    assign cnt_inc = (cnt < TO_LIM) ? cnt + 10'd1 : cnt;

    // State and registered bus outputs.
    always_ff @(posedge FASTCLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= 10'd0;
            STROBE  <= 1'b0;
            WRITE_B <= 1'b1;
            DEVICE  <= 16'd0;
            COMMAND <= 10'd0;
            BERR_B  <= 1'b1;
            TIMEOUT <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            STROBE  <= strobe_n;
            WRITE_B <= write_b_n;
            DEVICE  <= device_n;
            COMMAND <= command_n;
            BERR_B  <= berr_b_n;
            TIMEOUT <= timeout_n;
        end
    end

    // Next-state and next-output decode; outputs hold unless a state changes them.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        strobe_n  = STROBE;
        write_b_n = WRITE_B;
        device_n  = DEVICE;
        command_n = COMMAND;
        berr_b_n  = BERR_B;
        timeout_n = 1'b0;

        case (state)
            IDLE: begin
                if (!sync_as) begin
                    state_n = LATCH;
                end
            end

            LATCH: begin
                if (match) begin
                    device_n  = 16'h0001 << VME_ADDR[14:11];
                    command_n = VME_ADDR[10:1];
                    write_b_n = VME_WRITE_B;
                    state_n   = WAIT_DS;
                end else begin
                    device_n  = 16'd0;
                    state_n   = RELEASE;
                end
            end

            WAIT_DS: begin
                if (sync_as) begin
                    // Master gave up before the data phase.
                    device_n  = 16'd0;
                    command_n = 10'd0;
                    write_b_n = 1'b1;
                    state_n   = IDLE;
                end else if (!sync_ds) begin
                    strobe_n = 1'b1;
                    cnt_n    = 10'd0;
                    state_n  = STRB;
                end
            end

            STRB: begin
                if (sync_ds) begin
                    // Master ended the data phase; this wins over a timeout.
                    strobe_n = 1'b0;
                    device_n = 16'd0;
                    state_n  = RELEASE;
                end else if (sync_dtack) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == TO_LIM) begin
                        strobe_n  = 1'b0;
                        berr_b_n  = 1'b0;
                        timeout_n = 1'b1;
                        state_n   = ABORT;
                    end
                end
            end

            ABORT: begin
                if (sync_ds) begin
                    berr_b_n = 1'b1;
                    state_n  = RELEASE;
                end
            end

            RELEASE: begin
                if (sync_as && sync_ds) begin
                    device_n  = 16'd0;
                    command_n = 10'd0;
                    write_b_n = 1'b1;
                    state_n   = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vme_cycle_decode.sv
// Directed testbench for vme_cycle_decode (SYNC_STAGES=2, TIMEOUT_CYCLES=8).
// Inputs change 1 ns after each rising edge; outputs are checked there too.

module tb_vme_cycle_decode;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_DS = 3'd2;
    localparam logic [2:0] S_STRB    = 3'd3;
    localparam logic [2:0] S_ABORT   = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic        FASTCLK = 1'b0;
    logic        RST = 1'b1;
    logic        VME_AS_B = 1'b1;
    logic [1:0]  VME_DS_B = 2'b11;
    logic        VME_WRITE_B = 1'b1;
    logic [5:0]  VME_AM = 6'h39;
    logic [22:0] VME_ADDR = '0;
    logic [4:0]  GA = 5'd5;
    logic        DTACK_FB_B = 1'b1;
`ifdef GA_PARITY_CHECK_EN
    logic        GAP_B = 1'b0;
    logic        GA_PERR;
`endif
    logic        STROBE;
    logic        WRITE_B;
    logic [15:0] DEVICE;
    logic [9:0]  COMMAND;
    logic        BERR_B;
    logic        TIMEOUT;
    logic [2:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    vme_cycle_decode #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .FASTCLK     (FASTCLK),
        .RST         (RST),
        .VME_AS_B    (VME_AS_B),
        .VME_DS_B    (VME_DS_B),
        .VME_WRITE_B (VME_WRITE_B),
        .VME_AM      (VME_AM),
        .VME_ADDR    (VME_ADDR),
        .GA          (GA),
        .DTACK_FB_B  (DTACK_FB_B),
`ifdef GA_PARITY_CHECK_EN
        .GAP_B       (GAP_B),
        .GA_PERR     (GA_PERR),
`endif
        .STROBE      (STROBE),
        .WRITE_B     (WRITE_B),
        .DEVICE      (DEVICE),
        .COMMAND     (COMMAND),
        .BERR_B      (BERR_B),
        .TIMEOUT     (TIMEOUT),
        .state_dbg   (state_dbg)
    );

    // Clock
    always #5 FASTCLK = ~FASTCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge FASTCLK);
            #1;
        end
    endtask

    task automatic set_addr(input logic [4:0] slot, input logic [3:0] dev, input logic [9:0] cmd);
        VME_ADDR = {slot, 3'b000, dev, cmd, 1'b0};
    endtask

    // Clean matching read on slot 5, device 7, command 0x001, DTACK 3 cycles after STROBE.
    task automatic do_good_read();
        set_addr(5'd5, 4'h7, 10'h001);
        VME_AM      = 6'h39;
        VME_WRITE_B = 1'b1;
        VME_AS_B    = 1'b0;
        tick(4);
        check_eq("rd_state_wait_ds", state_dbg, S_WAIT_DS);
        check_eq("rd_device", DEVICE, 16'h0080);
        check_eq("rd_command", COMMAND, 10'h001);
        check_eq("rd_write_b", WRITE_B, 1'b1);
        check_eq("rd_strobe_pre", STROBE, 1'b0);
        VME_DS_B = 2'b00;
        tick(2);
        check_eq("rd_strobe_lat_lo", STROBE, 1'b0);
        tick(1);
        check_eq("rd_strobe_lat_hi", STROBE, 1'b1);
        tick(3);
        DTACK_FB_B = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_eq("rd_strobe_hold", STROBE, 1'b1);
            check_eq("rd_no_timeout", TIMEOUT, 1'b0);
        end
        check_eq("rd_device_hold", DEVICE, 16'h0080);
        VME_AS_B   = 1'b1;
        VME_DS_B   = 2'b11;
        DTACK_FB_B = 1'b1;
        tick(2);
        check_eq("rd_strobe_fall_lat_hi", STROBE, 1'b1);
        tick(1);
        check_eq("rd_strobe_fall", STROBE, 1'b0);
        check_eq("rd_berr_idle", BERR_B, 1'b1);
        tick(1);
        check_eq("rd_state_idle", state_dbg, S_IDLE);
        check_eq("rd_device_clr", DEVICE, 16'h0000);
        check_eq("rd_command_clr", COMMAND, 10'h000);
        check_eq("rd_write_b_clr", WRITE_B, 1'b1);
    endtask

    // Cycle the decoder must ignore: ends in RELEASE, never strobes.
    task automatic do_ignored(input string tag);
        VME_AS_B = 1'b0;
        tick(4);
        check_eq({tag, "_state_release"}, state_dbg, S_RELEASE);
        check_eq({tag, "_device"}, DEVICE, 16'h0000);
        VME_DS_B = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_eq({tag, "_no_strobe"}, STROBE, 1'b0);
        end
        VME_AS_B = 1'b1;
        VME_DS_B = 2'b11;
        tick(2);
        check_eq({tag, "_still_release"}, state_dbg, S_RELEASE);
        tick(1);
        check_eq({tag, "_state_idle"}, state_dbg, S_IDLE);
    endtask

    initial begin
        // Reset state
        tick(3);
        check_eq("rst_strobe", STROBE, 1'b0);
        check_eq("rst_write_b", WRITE_B, 1'b1);
        check_eq("rst_device", DEVICE, 16'h0000);
        check_eq("rst_command", COMMAND, 10'h000);
        check_eq("rst_berr_b", BERR_B, 1'b1);
        check_eq("rst_timeout", TIMEOUT, 1'b0);
        check_eq("rst_state", state_dbg, S_IDLE);
`ifdef GA_PARITY_CHECK_EN
        check_eq("rst_ga_perr", GA_PERR, 1'b0);
`endif
        RST = 1'b0;
        tick(2);

        // 1: clean read
        do_good_read();

        // 2: wrong slot
        set_addr(5'd6, 4'h7, 10'h001);
        VME_AM = 6'h39;
        do_ignored("slot");

        // 3: wrong address modifier
        set_addr(5'd5, 4'h7, 10'h001);
        VME_AM = 6'h29;
        do_ignored("am");

        // 4: write, no DTACK -> timeout after 8 STROBE cycles
        set_addr(5'd5, 4'hC, 10'h155);
        VME_AM      = 6'h3D;
        VME_WRITE_B = 1'b0;
        VME_AS_B    = 1'b0;
        tick(4);
        check_eq("wr_device", DEVICE, 16'h1000);
        check_eq("wr_command", COMMAND, 10'h155);
        check_eq("wr_write_b", WRITE_B, 1'b0);
        VME_DS_B = 2'b01;
        tick(3);
        check_eq("wr_strobe_hi", STROBE, 1'b1);
        for (int i = 1; i < 8; i++) begin
            tick(1);
            check_eq("wr_strobe_before_to", STROBE, 1'b1);
            check_eq("wr_timeout_before", TIMEOUT, 1'b0);
        end
        tick(1);
        check_eq("wr_strobe_to", STROBE, 1'b0);
        check_eq("wr_timeout_pulse", TIMEOUT, 1'b1);
        check_eq("wr_berr_asserted", BERR_B, 1'b0);
        check_eq("wr_state_abort", state_dbg, S_ABORT);
        tick(1);
        check_eq("wr_timeout_single", TIMEOUT, 1'b0);
        check_eq("wr_berr_hold", BERR_B, 1'b0);
        tick(3);
        check_eq("wr_berr_hold2", BERR_B, 1'b0);
        VME_DS_B = 2'b11;
        tick(2);
        check_eq("wr_berr_until_ds", BERR_B, 1'b0);
        tick(1);
        check_eq("wr_berr_released", BERR_B, 1'b1);
        check_eq("wr_state_release", state_dbg, S_RELEASE);
        VME_AS_B    = 1'b1;
        VME_WRITE_B = 1'b1;
        tick(3);
        check_eq("wr_state_idle", state_dbg, S_IDLE);
        check_eq("wr_write_b_clr", WRITE_B, 1'b1);

        // 5: reset in the middle of STRB
        set_addr(5'd5, 4'h3, 10'h2AA);
        VME_AM   = 6'h39;
        VME_AS_B = 1'b0;
        tick(4);
        VME_DS_B = 2'b00;
        tick(3);
        check_eq("mid_strobe_hi", STROBE, 1'b1);
        check_eq("mid_state_strb", state_dbg, S_STRB);
        tick(2);
        RST      = 1'b1;
        VME_AS_B = 1'b1;
        VME_DS_B = 2'b11;
        tick(1);
        check_eq("mid_rst_strobe", STROBE, 1'b0);
        check_eq("mid_rst_device", DEVICE, 16'h0000);
        check_eq("mid_rst_berr", BERR_B, 1'b1);
        check_eq("mid_rst_state", state_dbg, S_IDLE);
        RST = 1'b0;
        tick(3);
        check_eq("post_rst_idle", state_dbg, S_IDLE);
        do_good_read();

`ifdef GA_PARITY_CHECK_EN
        // 6: wrong geographic parity -> board ignores matching cycles
        GAP_B = 1'b1;
        tick(2);
        check_eq("par_perr_set", GA_PERR, 1'b1);
        set_addr(5'd5, 4'h7, 10'h001);
        VME_AM = 6'h39;
        do_ignored("par");
        GAP_B = 1'b0;
        tick(2);
        check_eq("par_perr_clr", GA_PERR, 1'b0);
        do_good_read();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
